// File: rtl/game_pkg.sv
// game_pkg: tile codes, direction codes and move-FSM states shared by the
// player movement logic.
package game_pkg;

  localparam logic [2:0] TILE_FLOOR = 3'd0;
  localparam logic [2:0] TILE_WALL  = 3'd1;
  localparam logic [2:0] TILE_VOID  = 3'd7;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    CHECK = 2'd2
  } state_t;

  // Anything other than solid wall or out-of-map void can be stepped on.
  function automatic logic isWalkable(input logic [2:0] tileType);
    return (tileType != TILE_WALL) && (tileType != TILE_VOID);
  endfunction

endpackage

// File: rtl/player_move_ctrl_btn_edge.sv
// btn_edge: registers one debounced button and raises a request on its rising
// edge; with MOVE_REPEAT_EN defined a held button also re-requests while idle.
module btn_edge #(
  parameter int REPEAT_DLY = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_level,
  input  logic i_idle,
  input  logic i_clear,
  output logic o_req
);

  logic r_prev;

  always_ff @(posedge clk) begin
    if (rst) r_prev <= 1'b0;
    else     r_prev <= i_level;
  end

`ifdef MOVE_REPEAT_EN
  localparam int CW = (REPEAT_DLY > 1) ? $clog2(REPEAT_DLY) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_fire;

  // Only idle cycles with the button still held count towards a repeat.
  assign w_fire = i_level & r_prev & i_idle & (r_cnt == CW'(REPEAT_DLY - 1));

  always_ff @(posedge clk) begin
    if (rst)                                     r_cnt <= '0;
    else if (!i_level || !r_prev || !i_idle || i_clear) r_cnt <= '0;
    else                                         r_cnt <= r_cnt + 1'b1;
  end

  assign o_req = (i_level & ~r_prev) | w_fire;
`else
  logic [31:0] w_unused;
  assign w_unused = 32'(REPEAT_DLY) ^ {30'd0, i_idle, i_clear};
  assign o_req    = i_level & ~r_prev;
`endif

endmodule

// File: rtl/player_move_ctrl.sv
// player_move_ctrl: turns button edges into map-checked grid moves.
// Hold-to-repeat moves are enabled by defining MOVE_REPEAT_EN.
module player_move_ctrl
  import game_pkg::*;
#(
  parameter int MAP_ROWS   = 15,
  parameter int MAP_COLS   = 20,
  parameter int START_R    = 1,
  parameter int START_C    = 1,
  parameter int MAP_LAT    = 2,
  parameter int REPEAT_DLY = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       up_pressed,
  input  logic       down_pressed,
  input  logic       left_pressed,
  input  logic       right_pressed,
  input  logic [2:0] dest_type,
  output logic [9:0] dest_r,
  output logic [9:0] dest_c,
  output logic       query_valid,
  output logic [9:0] pos_r,
  output logic [9:0] pos_c,
  output logic [1:0] facing,
  output logic       move_done,
  output logic       move_blocked
);

  localparam int            CW       = (MAP_LAT > 1) ? $clog2(MAP_LAT) : 1;
  localparam logic [CW-1:0] LAT_LAST = CW'(MAP_LAT - 1);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [9:0]    r_posR, r_posC, r_destR, r_destC;
  logic [1:0]    r_facing;
  logic          r_qv, r_done, r_blocked;

  logic [3:0] w_level, w_req;
  logic       w_idle, w_take, w_offGrid;
  logic [1:0] w_dir;
  logic [9:0] w_tgtR, w_tgtC;

  assign w_level = {right_pressed, left_pressed, down_pressed, up_pressed};
  assign w_idle  = (r_state == IDLE);
  assign w_take  = w_idle & (|w_req);

  for (genvar gi = 0; gi < 4; gi++) begin : g_btn
    btn_edge #(.REPEAT_DLY(REPEAT_DLY)) u_btn (
      .clk     (clk),
      .rst     (rst),
      .i_level (w_level[gi]),
      .i_idle  (w_idle),
      .i_clear (w_take),
      .o_req   (w_req[gi])
    );
  end

  // Pick one direction by priority; the edge test guards every decrement.
  always_comb begin
    w_dir     = DIR_RIGHT;
    w_offGrid = 1'b0;
    w_tgtR    = r_posR;
    w_tgtC    = r_posC;
    if      (w_req[DIR_UP])   w_dir = DIR_UP;
    else if (w_req[DIR_DOWN]) w_dir = DIR_DOWN;
    else if (w_req[DIR_LEFT]) w_dir = DIR_LEFT;
    case (w_dir)
      DIR_UP: begin
        w_offGrid = (r_posR == 10'd0);
        if (!w_offGrid) w_tgtR = r_posR - 10'd1;
      end
      DIR_DOWN: begin
        w_offGrid = (r_posR == 10'(MAP_ROWS - 1));
        if (!w_offGrid) w_tgtR = r_posR + 10'd1;
      end
      DIR_LEFT: begin
        w_offGrid = (r_posC == 10'd0);
        if (!w_offGrid) w_tgtC = r_posC - 10'd1;
      end
      default: begin
        w_offGrid = (r_posC == 10'(MAP_COLS - 1));
        if (!w_offGrid) w_tgtC = r_posC + 10'd1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_posR    <= 10'(START_R);
      r_posC    <= 10'(START_C);
      r_destR   <= 10'(START_R);
      r_destC   <= 10'(START_C);
      r_facing  <= DIR_DOWN;
      r_qv      <= 1'b0;
      r_done    <= 1'b0;
      r_blocked <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_blocked <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_take) begin
            r_facing <= w_dir;
            if (w_offGrid) begin
              r_blocked <= 1'b1;
            end else begin
              r_destR <= w_tgtR;
              r_destC <= w_tgtC;
              r_qv    <= 1'b1;
              r_cnt   <= '0;
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (r_cnt == LAT_LAST) r_state <= CHECK;
          else                   r_cnt   <= r_cnt + 1'b1;
        end
        CHECK: begin
          if (isWalkable(dest_type)) begin
            r_posR <= r_destR;
            r_posC <= r_destC;
            r_done <= 1'b1;
          end else begin
            r_blocked <= 1'b1;
          end
          r_qv    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign dest_r       = r_destR;
  assign dest_c       = r_destC;
  assign query_valid  = r_qv;
  assign pos_r        = r_posR;
  assign pos_c        = r_posC;
  assign facing       = r_facing;
  assign move_done    = r_done;
  assign move_blocked = r_blocked;

endmodule

// File: tb/tb_player_move_ctrl.sv
// tb_player_move_ctrl: directed scenarios plus random button traffic, checked
// every cycle against a move-level model of the player controller.
module tb_player_move_ctrl;
  import game_pkg::*;

  localparam int MAP_ROWS   = 15;
  localparam int MAP_COLS   = 20;
  localparam int START_R    = 1;
  localparam int START_C    = 1;
  localparam int MAP_LAT    = 2;
  localparam int REPEAT_DLY = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn = 4'd0;
  logic [2:0] dest_type;
  logic [9:0] dest_r, dest_c, pos_r, pos_c;
  logic       query_valid, move_done, move_blocked;
  logic [1:0] facing;

  logic [2:0] tileMap [MAP_ROWS][MAP_COLS];
  logic [2:0] mapPipe [MAP_LAT];

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  player_move_ctrl #(
    .MAP_ROWS(MAP_ROWS), .MAP_COLS(MAP_COLS), .START_R(START_R),
    .START_C(START_C), .MAP_LAT(MAP_LAT), .REPEAT_DLY(REPEAT_DLY)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .up_pressed    (btn[0]),
    .down_pressed  (btn[1]),
    .left_pressed  (btn[2]),
    .right_pressed (btn[3]),
    .dest_type     (dest_type),
    .dest_r        (dest_r),
    .dest_c        (dest_c),
    .query_valid   (query_valid),
    .pos_r         (pos_r),
    .pos_c         (pos_c),
    .facing        (facing),
    .move_done     (move_done),
    .move_blocked  (move_blocked)
  );

  function automatic logic [2:0] tileAt(input int r, input int c);
    if (r < 0 || r >= MAP_ROWS || c < 0 || c >= MAP_COLS) return 3'd1;
    return tileMap[r][c];
  endfunction

  // Map-type block: answers MAP_LAT cycles after a live query, wall otherwise.
  always @(posedge clk) begin
    mapPipe[0] <= query_valid ? tileAt(int'(dest_r), int'(dest_c)) : 3'd1;
    for (int i = 1; i < MAP_LAT; i++) mapPipe[i] <= mapPipe[i-1];
  end
  assign dest_type = mapPipe[MAP_LAT-1];

  // Move-level model: a request either blocks at once or occupies the
  // controller for MAP_LAT+1 cycles and resolves on the last of them.
  int mPosR, mPosC, mFace, mDestR, mDestC, mQv, mDone, mBlk, mBusy;
  int mPrev [4];
  int mHeld [4];
  int req   [4];
  int pick;
  int tgtR, tgtC;
  logic [2:0] tgtTile;

  always @(posedge clk) begin
    if (rst) begin
      mPosR = START_R; mPosC = START_C; mFace = 1;
      mDestR = START_R; mDestC = START_C;
      mQv = 0; mDone = 0; mBlk = 0; mBusy = 0;
      for (int d = 0; d < 4; d++) begin mPrev[d] = 0; mHeld[d] = 0; end
    end else begin
      mDone = 0; mBlk = 0;
      for (int d = 0; d < 4; d++) req[d] = (btn[d] && mPrev[d] == 0) ? 1 : 0;
`ifdef MOVE_REPEAT_EN
      for (int d = 0; d < 4; d++) begin
        if (btn[d] && mPrev[d] == 1 && mBusy == 0) begin
          mHeld[d]++;
          if (mHeld[d] == REPEAT_DLY) req[d] = 1;
        end else begin
          mHeld[d] = 0;
        end
      end
`endif
      if (mBusy > 0) begin
        mBusy--;
        if (mBusy == 0) begin
          tgtTile = tileAt(mDestR, mDestC);
          if (tgtTile != 3'd1 && tgtTile != 3'd7) begin
            mPosR = mDestR; mPosC = mDestC; mDone = 1;
          end else begin
            mBlk = 1;
          end
          mQv = 0;
        end
      end else begin
        pick = -1;
        for (int d = 3; d >= 0; d--) if (req[d] == 1) pick = d;
        if (pick >= 0) begin
          for (int d = 0; d < 4; d++) mHeld[d] = 0;
          mFace = pick;
          tgtR = mPosR + ((pick == 0) ? -1 : (pick == 1) ? 1 : 0);
          tgtC = mPosC + ((pick == 2) ? -1 : (pick == 3) ? 1 : 0);
          if (tgtR < 0 || tgtR >= MAP_ROWS || tgtC < 0 || tgtC >= MAP_COLS) begin
            mBlk = 1;
          end else begin
            mDestR = tgtR; mDestC = tgtC; mQv = 1; mBusy = MAP_LAT + 1;
          end
        end
      end
      for (int d = 0; d < 4; d++) mPrev[d] = btn[d] ? 1 : 0;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    checkOutput("pos_r",        int'(pos_r),        mPosR);
    checkOutput("pos_c",        int'(pos_c),        mPosC);
    checkOutput("facing",       int'(facing),       mFace);
    checkOutput("dest_r",       int'(dest_r),       mDestR);
    checkOutput("dest_c",       int'(dest_c),       mDestC);
    checkOutput("query_valid",  int'(query_valid),  mQv);
    checkOutput("move_done",    int'(move_done),    mDone);
    checkOutput("move_blocked", int'(move_blocked), mBlk);
  end

  task automatic doReset();
    @(negedge clk); rst = 1'b1; btn = 4'd0;
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
  endtask

  // Press the buttons for one cycle and watch the controller for a while.
  task automatic applyStimulus(input logic [3:0] press, output int qvCnt,
                               output int doneCnt, output int blkCnt,
                               output int lastR, output int lastC);
    qvCnt = 0; doneCnt = 0; blkCnt = 0; lastR = -1; lastC = -1;
    @(negedge clk); btn = press;
    for (int i = 0; i < MAP_LAT + 8; i++) begin
      @(negedge clk);
      if (i == 0) btn = 4'd0;
      if (query_valid) begin qvCnt++; lastR = int'(dest_r); lastC = int'(dest_c); end
      if (move_done)    doneCnt++;
      if (move_blocked) blkCnt++;
    end
  endtask

  int qv, dn, bk, lr, lc;

  initial begin
    for (int r = 0; r < MAP_ROWS; r++)
      for (int c = 0; c < MAP_COLS; c++) tileMap[r][c] = 3'd0;
    tileMap[0][1] = 3'd1;
    tileMap[2][3] = 3'd1;
    tileMap[3][3] = 3'd7;
    tileMap[4][8] = 3'd1;

    doReset();
    checkOutput("rst_pos_r", int'(pos_r), 1);
    checkOutput("rst_pos_c", int'(pos_c), 1);
    checkOutput("rst_facing", int'(facing), 1);
    checkOutput("rst_qv", int'(query_valid), 0);

    applyStimulus(4'b1000, qv, dn, bk, lr, lc);
    checkOutput("t1_qv_cycles", qv, MAP_LAT + 1);
    checkOutput("t1_dest_r", lr, 1);
    checkOutput("t1_dest_c", lc, 2);
    checkOutput("t1_pos_c", int'(pos_c), 2);
    checkOutput("t1_facing", int'(facing), 3);
    checkOutput("t1_done", dn, 1);

    doReset();
    applyStimulus(4'b0001, qv, dn, bk, lr, lc);
    checkOutput("t2_dest_r", lr, 0);
    checkOutput("t2_dest_c", lc, 1);
    checkOutput("t2_pos_r", int'(pos_r), 1);
    checkOutput("t2_facing", int'(facing), 0);
    checkOutput("t2_blocked", bk, 1);
    checkOutput("t2_done", dn, 0);

    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(4'b1000, qv, dn, bk, lr, lc);
    applyStimulus(4'b0001, qv, dn, bk, lr, lc);
    checkOutput("t3_at_row0", int'(pos_r), 0);
    applyStimulus(4'b0001, qv, dn, bk, lr, lc);
    checkOutput("t3_up_qv", qv, 0);
    checkOutput("t3_up_blk", bk, 1);
    checkOutput("t3_up_pos_c", int'(pos_c), 5);
    for (int i = 0; i < 14; i++) applyStimulus(4'b1000, qv, dn, bk, lr, lc);
    for (int i = 0; i < 14; i++) applyStimulus(4'b0010, qv, dn, bk, lr, lc);
    checkOutput("t3_corner_r", int'(pos_r), 14);
    checkOutput("t3_corner_c", int'(pos_c), 19);
    applyStimulus(4'b0010, qv, dn, bk, lr, lc);
    checkOutput("t3_down_qv", qv, 0);
    checkOutput("t3_down_blk", bk, 1);
    applyStimulus(4'b1000, qv, dn, bk, lr, lc);
    checkOutput("t3_right_qv", qv, 0);
    checkOutput("t3_right_blk", bk, 1);
    checkOutput("t3_right_pos_c", int'(pos_c), 19);

    doReset();
    applyStimulus(4'b0101, qv, dn, bk, lr, lc);
    checkOutput("t4_dest_r", lr, 0);
    checkOutput("t4_dest_c", lc, 1);
    checkOutput("t4_facing", int'(facing), 0);
    checkOutput("t4_pos_c", int'(pos_c), 1);
    checkOutput("t4_done", dn, 0);

    doReset();
    @(negedge clk); btn = 4'b1000;
    @(negedge clk); rst = 1'b1; btn = 4'd0;
    @(negedge clk); rst = 1'b0;
    checkOutput("t5_pos_c", int'(pos_c), 1);
    checkOutput("t5_qv", int'(query_valid), 0);
    dn = 0; bk = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (move_done) dn++;
      if (move_blocked) bk++;
    end
    checkOutput("t5_pulses", dn + bk, 0);

    doReset();
    @(negedge clk); btn = 4'b1000;
    repeat (40) @(negedge clk);
    btn = 4'd0;
    repeat (15) @(negedge clk);
`ifdef MOVE_REPEAT_EN
    checkOutput("t6_repeat_pos_c", int'(pos_c), 5);
`else
    checkOutput("t6_single_pos_c", int'(pos_c), 2);
`endif

    doReset();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 3) == 0) btn = 4'($urandom_range(0, 15));
      else if ($urandom_range(0, 2) == 0) btn = 4'd0;
    end
    @(negedge clk); rst = 1'b0; btn = 4'd0;
    repeat (MAP_LAT + 4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
